dcache_wt: RTL
==============

Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache; responder end of the MEM-stage DCache CPU interface.
- Serves CPU load/store requests and converts misses, stores and uncached accesses into single classic Wishbone transactions toward the memory bus.
- Services FENCE.I invalidation requests.
- Sits in the CPU top between the MEM stage and the Wishbone arbiter.

Parameters:
- NUM_LINES, 64, number of one-word lines; power of two, ≥2.
- UNCACHED_NIBBLE, 4'h1, addr[31:28] value that bypasses the cache (MMIO).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cpu_addr_i  in  32  byte address; bits [1:0] ignored for lookup
- cpu_wdata_i  in  32  store data, lane-replicated by the requester
- cpu_we_i  in  1  1=store, 0=load
- cpu_be_i  in  4  byte enables
- cpu_valid_i  in  1  request; held stable until cpu_ready_o
- cpu_rdata_o  out  32  load data, valid while cpu_ready_o=1
- cpu_ready_o  out  1  one-cycle completion pulse
- flush_req_i  in  1  FENCE.I invalidate request, level, held until flush_done_o
- flush_done_o  out  1  one-cycle pulse when invalidation is complete
- wb_cyc_o, wb_stb_o  out  1 each  Wishbone cycle/strobe, always equal
- wb_we_o  out  1  Wishbone write enable
- wb_adr_o  out  32  {cpu_addr_i[31:2],2'b00}
- wb_dat_o  out  32  cpu_wdata_i
- wb_sel_o  out  4  cpu_be_i for stores; 4'b1111 for loads
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Geometry: IDX_W = log2(NUM_LINES); index = addr[IDX_W+1:2]; tag = addr[31:IDX_W+2] (24 bits at default). Per-line storage: valid bit, tag, 32-bit data. Arrays read combinationally.
- Reset:
  - All valid bits cleared; state IDLE; flush counter 0.
  - All outputs 0: cpu_ready_o, cpu_rdata_o, flush_done_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o.
  - Reset mid-transaction drops wb_cyc_o/wb_stb_o immediately (asynchronous) and abandons the access; no line is filled.
- Definitions: hit = valid[idx] && tag match && addr[31:28] != UNCACHED_NIBBLE.
- States: IDLE, WB_READ, WB_WRITE, FLUSH.
- IDLE:
  - cpu_valid_i && !cpu_we_i && hit: cpu_ready_o=1 in the same cycle (combinational), cpu_rdata_o = line data; remain IDLE. Zero-latency hit.
  - cpu_valid_i && !cpu_we_i && !hit: go to WB_READ; no ready this cycle.
  - cpu_valid_i && cpu_we_i: go to WB_WRITE. Stores never complete in IDLE.
  - !cpu_valid_i && flush_req_i: go to FLUSH; counter = 0.
  - A pending cpu_valid_i has priority over flush_req_i.
- WB_READ:
  - wb_cyc_o=wb_stb_o=1, wb_we_o=0, wb_sel_o=4'b1111; driven registered from the first cycle in state.
  - On wb_ack_i: cpu_ready_o=1 and cpu_rdata_o = wb_dat_i in the same cycle.
  - If the address is cacheable, line[idx] is written {valid=1, tag, wb_dat_i} at that edge.
  - Return to IDLE. Bus signals deassert in the cycle after ack.
- WB_WRITE:
  - wb_cyc_o=wb_stb_o=wb_we_o=1, wb_sel_o=cpu_be_i.
  - On wb_ack_i: cpu_ready_o=1.
  - If the store hit, only the enabled bytes of line data are updated at that edge. A miss is not allocated.
  - Return to IDLE.
- Ready and bus rules:
  - cpu_ready_o is never high on two consecutive cycles for the same request.
  - cpu_ready_o is 0 whenever cpu_valid_i=0.
  - wb_ack_i outside WB_READ/WB_WRITE is ignored.
- FLUSH:
  - One line per cycle: valid[counter] cleared at each edge; counter increments.
  - After clearing line NUM_LINES-1, go to IDLE with flush_done_o=1 (registered) for that first IDLE cycle.
  - Total time: flush_done_o rises NUM_LINES+1 cycles after the accepting IDLE cycle.
  - cpu_ready_o=0 during FLUSH; cpu_valid_i is held off until IDLE.
  - flush_req_i still high on the flush_done_o cycle does not restart a flush. A new flush needs flush_req_i low for at least one cycle.
- Write-through: the cache is never dirty, so FLUSH performs no bus writes.

Decomposition:
- Package dcache_pkg:
  - dcache_state_t enum (IDLE, WB_READ, WB_WRITE, FLUSH)
  - line struct {valid, tag, data}
  - function is_uncached(addr, nibble)
  - function byte_merge(old, new, be)
- One sub-module, dcache_array: valid/tag/data storage with a combinational read port, a fill/byte-merge write port, a per-index valid-clear port, and async reset of valid bits.

Test Plan:
- Cold load 0x80000100; bus acks 0xDEADBEEF after 3 wait cycles → cpu_ready_o pulses on the ack cycle with rdata 0xDEADBEEF. Repeat load → ready in the same cycle, wb_cyc_o stays 0.
- After case 1, store byte at 0x80000101, be=4'b0010, wdata=0x5A5A5A5A → bus write with adr 0x80000100, sel 0010; ready on ack. Next load of 0x80000100 hits with 0xDEAD5AEF.
- Load 0x10000000 twice, bus returns 0x11 then 0x22 → two bus reads; rdata 0x11 then 0x22; no fill.
- Load 0x80000100 (fill) then 0x80010100 (same index, new tag) → second access misses; reload of 0x80000100 misses again.
- Fill 3 lines, assert flush_req_i → flush_done_o rises exactly 65 cycles later (NUM_LINES=64), single pulse. All three addresses then miss.
- Assert rst during WB_READ before ack → wb_cyc_o=0 immediately. After release, the same load misses (no stale line) and completes normally.

Source files
------------

// File: rtl/dcache_wt_pkg.sv
// Shared types and helpers for the write-through data cache.
// Line layout, FSM state encoding, uncached-window test, byte merge.
package dcache_pkg;

  localparam int TAG_MAX = 30;

  typedef enum logic [1:0] {
    IDLE,
    WB_READ,
    WB_WRITE,
    FLUSH
  } dcache_state_t;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [31:0]        data;
  } line_t;

  function automatic logic is_uncached(
    input logic [31:0] addr,
    input logic [3:0]  nibble
  );
    return (addr >> 28) == 32'(nibble);
  endfunction

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_wt_if.sv
// CPU-side request port and Wishbone master port of the data cache.
// CPU side: master = MEM stage, slave = cache. Bus side: master = cache.
interface dcache_cpu_if;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_be_i;
  logic        cpu_valid_i;
  logic [31:0] cpu_rdata_o;
  logic        cpu_ready_o;
  logic        flush_req_i;
  logic        flush_done_o;

  modport master (
    output cpu_addr_i, cpu_wdata_i, cpu_we_i,
    output cpu_be_i, cpu_valid_i, flush_req_i,
    input  cpu_rdata_o, cpu_ready_o, flush_done_o
  );

  modport slave (
    input  cpu_addr_i, cpu_wdata_i, cpu_we_i,
    input  cpu_be_i, cpu_valid_i, flush_req_i,
    output cpu_rdata_o, cpu_ready_o, flush_done_o
  );
endinterface

interface dcache_wb_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/dcache_wt_array.sv
// Valid/tag/data storage: combinational read, fill or byte-merge write,
// per-index valid clear. Only valid bits are reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output line_t            rd_line_o,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             fill_en_i,
  input  logic [TAG_W-1:0] fill_tag_i,
  input  logic [31:0]      fill_data_i,
  input  logic             merge_en_i,
  input  logic [31:0]      merge_data_i,
  input  logic [3:0]       merge_be_i,
  input  logic             clr_en_i,
  input  logic [IDX_W-1:0] clr_idx_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (fill_en_i) valid_q[wr_idx_i] <= 1'b1;
      if (clr_en_i)  valid_q[clr_idx_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[wr_idx_i]  <= fill_tag_i;
      data_q[wr_idx_i] <= fill_data_i;
    end else if (merge_en_i) begin
      data_q[wr_idx_i] <= byte_merge(data_q[wr_idx_i],
                                     merge_data_i,
                                     merge_be_i);
    end
  end

  always_comb begin
    rd_line_o.valid = valid_q[rd_idx_i];
    rd_line_o.tag   = TAG_MAX'(tag_q[rd_idx_i]);
    rd_line_o.data  = data_q[rd_idx_i];
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache between the
// MEM stage and the Wishbone arbiter, with FENCE.I line-by-line flush.
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int         NUM_LINES       = 64,
  parameter logic [3:0] UNCACHED_NIBBLE = 4'h1
) (
  input  logic         clk,
  input  logic         rst,
  dcache_cpu_if.slave  cpu,
  dcache_wb_if.master  wb
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - IDX_W;

  dcache_state_t    state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             armed_q, armed_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  line_t            line;
  logic             uncached, hit;
  logic             ready, fill_en, merge_en, clr_en;
  logic [31:0]      rdata;
  logic             bus_rd, bus_wr, bus;

  assign idx      = cpu.cpu_addr_i[IDX_W+1:2];
  assign tag      = cpu.cpu_addr_i[31:IDX_W+2];
  assign uncached = is_uncached(cpu.cpu_addr_i, UNCACHED_NIBBLE);
  assign hit      = line.valid && (line.tag == TAG_MAX'(tag)) && !uncached;

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk          (clk),
    .rst          (rst),
    .rd_idx_i     (idx),
    .rd_line_o    (line),
    .wr_idx_i     (idx),
    .fill_en_i    (fill_en),
    .fill_tag_i   (tag),
    .fill_data_i  (wb.wb_dat_i),
    .merge_en_i   (merge_en),
    .merge_data_i (cpu.cpu_wdata_i),
    .merge_be_i   (cpu.cpu_be_i),
    .clr_en_i     (clr_en),
    .clr_idx_i    (cnt_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      armed_q <= armed_d;
    end
  end

  // armed_q forces flush_req_i low for a cycle between two flushes
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    armed_d  = armed_q | ~cpu.flush_req_i;
    ready    = 1'b0;
    rdata    = '0;
    fill_en  = 1'b0;
    merge_en = 1'b0;
    clr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu.cpu_valid_i) begin
          if (cpu.cpu_we_i) begin
            state_d = WB_WRITE;
          end else if (hit) begin
            ready = 1'b1;
            rdata = line.data;
          end else begin
            state_d = WB_READ;
          end
        end else if (cpu.flush_req_i && armed_q) begin
          state_d = FLUSH;
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end
      WB_READ: begin
        if (wb.wb_ack_i) begin
          ready   = 1'b1;
          rdata   = wb.wb_dat_i;
          fill_en = !uncached;
          state_d = IDLE;
        end
      end
      WB_WRITE: begin
        if (wb.wb_ack_i) begin
          ready    = 1'b1;
          merge_en = hit;
          state_d  = IDLE;
        end
      end
      FLUSH: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(NUM_LINES - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  assign bus_rd = (state_q == WB_READ);
  assign bus_wr = (state_q == WB_WRITE);
  assign bus    = bus_rd | bus_wr;

  assign wb.wb_cyc_o = bus;
  assign wb.wb_stb_o = bus;
  assign wb.wb_we_o  = bus_wr;
  assign wb.wb_adr_o = bus ? (cpu.cpu_addr_i & ~32'h3) : '0;
  assign wb.wb_dat_o = bus_wr ? cpu.cpu_wdata_i : '0;
  assign wb.wb_sel_o = bus_wr ? cpu.cpu_be_i
                     : bus_rd ? 4'hF : 4'h0;

  assign cpu.cpu_ready_o  = ready & cpu.cpu_valid_i;
  assign cpu.cpu_rdata_o  = cpu.cpu_valid_i ? rdata : '0;
  assign cpu.flush_done_o = done_q;

endmodule
